// File: rtl/link_arbiter.sv
// link_arbiter: round-robin arbiter that serialises one requester's packet at a time onto sdata.
// Define LINK_ARBITER_PARITY_EN to append an even-parity bit after the data bits.
module link_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PACKET_SIZE = 4,
  parameter int LEAD_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PACKET_SIZE-1:0] data_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           rec_sig,
  output logic                           sdata,
  output logic                           busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(PACKET_SIZE + 1);
  localparam int LW = $clog2(LEAD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SEND,
    S_GAP
`ifdef LINK_ARBITER_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t                 state;
  logic [IW-1:0]          last;
  logic [BW-1:0]          bit_cnt;
  logic [LW-1:0]          lead_cnt;
  logic [PACKET_SIZE-1:0] pkt;
  logic [PACKET_SIZE-1:0] slice;
  logic [IW-1:0]          win;
  logic [IW-1:0]          idx;
  logic                   win_vld;
  logic                   cur_bit;

  // Search starts just past the last winner so a re-requester yields to everyone else.
  always_comb begin
    win     = last;
    idx     = last;
    win_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign slice   = data_in[int'(win)*PACKET_SIZE +: PACKET_SIZE];
  assign cur_bit = |(pkt & (PACKET_SIZE'(1) << bit_cnt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      ack      <= '0;
      rec_sig  <= 1'b0;
      sdata    <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      lead_cnt <= '0;
      pkt      <= '0;
      last     <= IW'(NUM_REQ - 1);
    end else begin
      rec_sig <= 1'b0;
      ack     <= '0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            state    <= S_LEAD;
            grant    <= NUM_REQ'(1) << win;
            last     <= win;
            pkt      <= slice;
            rec_sig  <= 1'b1;
            busy     <= 1'b1;
            sdata    <= 1'b0;
            lead_cnt <= LW'(1);
          end
        end
        S_LEAD: begin
          if (lead_cnt == LW'(LEAD_CYCLES)) begin
            state    <= S_SEND;
            sdata    <= pkt[0];
            bit_cnt  <= BW'(1);
            lead_cnt <= '0;
          end else begin
            lead_cnt <= lead_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (bit_cnt == BW'(PACKET_SIZE)) begin
            bit_cnt <= '0;
`ifdef LINK_ARBITER_PARITY_EN
            state   <= S_PAR;
            sdata   <= ^pkt;
`else
            state   <= S_GAP;
            sdata   <= 1'b0;
            ack     <= grant;
`endif
          end else begin
            sdata   <= cur_bit;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef LINK_ARBITER_PARITY_EN
        S_PAR: begin
          state <= S_GAP;
          sdata <= 1'b0;
          ack   <= grant;
        end
`endif
        S_GAP: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
          sdata <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_link_arbiter.sv
// Scoreboard bench for link_arbiter: expected packets are queued at stimulus time and
// checked cycle by cycle against the observed output bundle.
module tb_link_arbiter;
  localparam int N = 4;
  localparam int P = 4;
  localparam int L = 3;
`ifdef LINK_ARBITER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int GAP_K  = L + P + PB;
  localparam int IDLE_K = GAP_K + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*P-1:0] data_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           rec_sig;
  logic           sdata;
  logic           busy;
  logic [2*N+2:0] outs;

  link_arbiter #(.NUM_REQ(N), .PACKET_SIZE(P), .LEAD_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(grant), .ack(ack), .rec_sig(rec_sig), .sdata(sdata), .busy(busy)
  );

  always #5 clk = ~clk;
  assign outs = {grant, ack, rec_sig, sdata, busy};

  typedef struct {
    logic [N-1:0] g;
    logic [P-1:0] d;
    bit           b2b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_last;
  int   pk = -1;
  bit   mon_en = 1'b0;
  bit   need_start = 1'b0;
  exp_t cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (r[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  task automatic push_pkt(input logic [N-1:0] r, input bit b2b);
    int   w;
    exp_t e;
    w        = rr_pick(r, exp_last);
    exp_last = w;
    e.g      = N'(1 << w);
    e.d      = data_in[w*P +: P];
    e.b2b    = b2b;
    sb.push_back(e);
  endtask

  task automatic set_slice(input int i, input logic [P-1:0] v);
    data_in[i*P +: P] = v;
  endtask

  // Monitor: one full-bundle comparison per cycle while a packet is in flight.
  always @(negedge clk) begin
    logic [N-1:0]   g;
    logic [N-1:0]   a;
    logic           r;
    logic           s;
    logic           b;
    logic [2*N+2:0] want;
    string          tag;
    if (!mon_en) begin
      pk         = -1;
      need_start = 1'b0;
    end else begin
      if (pk < 0) begin
        if (need_start) check_eq("b2b_start", rec_sig, 1);
        need_start = 1'b0;
        if (rec_sig && sb.size() > 0) begin
          cur = sb.pop_front();
          pk  = 0;
        end else begin
          check_eq(rec_sig ? "unexpected_pkt" : "idle", outs, 0);
        end
      end
      if (pk >= 0) begin
        g = cur.g; a = '0; r = (pk == 0); s = 1'b0; b = 1'b1; tag = "lead";
        if (pk >= L && pk < L + P) begin
          s = cur.d[pk-L]; tag = "data";
        end
        if (PB == 1 && pk == L + P) begin
          s = ^cur.d; tag = "parity";
        end
        if (pk == GAP_K) begin
          a = cur.g; tag = "gap_ack";
        end
        if (pk == IDLE_K) begin
          g = '0; b = 1'b0; tag = "idle_after";
        end
        want = {g, a, r, s, b};
        check_eq(tag, outs, want);
        pk++;
        if (pk > IDLE_K) begin
          pk         = -1;
          need_start = (sb.size() > 0) && sb[0].b2b;
        end
      end
    end
  end

  task automatic do_reset(input string tag);
    reset  = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    check_eq(tag, outs, 0);
    reset = 1'b0;
    sb.delete();
    exp_last = N - 1;
    mon_en   = 1'b1;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (grant != 0) return;
    end
    check_eq("grant_timeout", busy, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && pk >= 0) return;
    end
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_phase(input int n);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (pk >= n) return;
    end
    check_eq("phase_timeout", pk, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && pk < 0) return;
    end
    check_eq("idle_timeout", pk < 0, 1);
  endtask

  initial begin
    req     = '0;
    data_in = '0;
    do_reset("reset_outs");

    // single request
    set_slice(0, 4'b1011);
    push_pkt(4'b0001, 1'b0);
    req = 4'b0001;
    wait_grant();
    req = '0;
    wait_idle();

    // all requesting: 0,1,2,3,0 back to back
    do_reset("reset_rr");
    set_slice(1, 4'b0110);
    set_slice(2, 4'b1001);
    set_slice(3, 4'b0011);
    push_pkt(4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) push_pkt(4'b1111, 1'b1);
    req = 4'b1111;
    wait_drain();
    req = '0;
    wait_idle();

    // requester 1 drops req and changes data mid-SEND
    push_pkt(4'b0010, 1'b0);
    req = 4'b0010;
    wait_phase(L + 1);
    req = '0;
    set_slice(1, 4'b1001);
    wait_idle();

    // sole requester held through ack is regranted after one idle cycle
    push_pkt(4'b0100, 1'b0);
    push_pkt(4'b0100, 1'b1);
    req = 4'b0100;
    wait_drain();
    req = '0;
    wait_idle();

    // wrap-around search, then fairness between two holders
    push_pkt(4'b0101, 1'b0);
    push_pkt(4'b0101, 1'b1);
    req = 4'b0101;
    wait_drain();
    req = '0;
    wait_idle();

    // reset two data bits into SEND
    push_pkt(4'b0001, 1'b0);
    req = 4'b0001;
    wait_grant();
    req = '0;
    wait_phase(L + 2);
    do_reset("reset_mid_send");
    repeat (3) @(posedge clk);
    #1;

    // pointer back at NUM_REQ-1: requester 0 beats requester 2
    push_pkt(4'b0101, 1'b0);
    req = 4'b0101;
    wait_grant();
    req = '0;
    wait_idle();
    push_pkt(4'b0100, 1'b0);
    req = 4'b0100;
    wait_grant();
    req = '0;
    wait_idle();

    check_eq("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
